// File: rtl/alu_result_stage.sv
// Registered result stage behind the adder/subtractor: flag masking, 2-entry skid
// buffer on a valid/ready handshake, sticky overflow and saturating overflow counter.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic             in_cout,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_cout,
    output logic             out_negative,
    output logic             sticky_ovf,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
        logic             cout;
        logic             negative;
    } entry_t;

    state_t           state_reg, state_next;
    entry_t           head_reg, head_next;
    entry_t           skid_reg, skid_next;
    entry_t           captured;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;
    logic             sticky_reg, sticky_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic accept;
    logic pop;
    logic is_slt;
    logic ovf_event;

    assign accept    = in_valid & in_ready_reg;
    assign pop       = out_valid_reg & out_ready;
    assign is_slt    = (in_op == 2'b11);
    assign ovf_event = accept & in_overflow & ~is_slt;

    // SLT result is a 0/1 compare outcome, so arithmetic flags are meaningless there.
    always_comb begin
        captured.result   = in_result;
        captured.zero     = in_zero;
        captured.overflow = is_slt ? 1'b0 : in_overflow;
        captured.cout     = is_slt ? 1'b0 : in_cout;
        captured.negative = is_slt ? 1'b0 : in_result[WIDTH-1];
    end

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    head_next  = captured;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_next = captured;
                end else if (accept) begin
                    skid_next  = captured;
                    state_next = TWO;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_next  = skid_reg;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs come straight from flops so consumer back-pressure never
    // reaches the adder through logic.
    always_comb begin
        in_ready_next  = (state_next != TWO);
        out_valid_next = (state_next != EMPTY);
    end

    // A clear coinciding with an overflow accept restarts the count at one.
    always_comb begin
        sticky_next = sticky_reg;
        count_next  = count_reg;
        if (ovf_event) begin
            sticky_next = 1'b1;
            if (sticky_clr) begin
                count_next = CNT_W'(1);
            end else if (count_reg != {CNT_W{1'b1}}) begin
                count_next = count_reg + CNT_W'(1);
            end
        end else if (sticky_clr) begin
            sticky_next = 1'b0;
            count_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            head_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            sticky_reg    <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            head_reg      <= head_next;
            skid_reg      <= skid_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            sticky_reg    <= sticky_next;
            count_reg     <= count_next;
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign out_result   = head_reg.result;
    assign out_zero     = head_reg.zero;
    assign out_overflow = head_reg.overflow;
    assign out_cout     = head_reg.cout;
    assign out_negative = head_reg.negative;
    assign sticky_ovf   = sticky_reg;
    assign ovf_count    = count_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: streaming, back-pressure, SLT masking,
// overflow sticky/counter behaviour, saturation and mid-stream reset.
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_zero;
    logic             in_overflow;
    logic             in_cout;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_overflow;
    logic             out_cout;
    logic             out_negative;
    logic             sticky_ovf;
    logic             sticky_clr;
    logic [CNT_W-1:0] ovf_count;

    int checks = 0;
    int errors = 0;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .in_cout      (in_cout),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_cout     (out_cout),
        .out_negative (out_negative),
        .sticky_ovf   (sticky_ovf),
        .sticky_clr   (sticky_clr),
        .ovf_count    (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are changed only after this returns.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic z,
                         input logic o, input logic c, input logic [1:0] op);
        in_valid    = v;
        in_result   = r;
        in_zero     = z;
        in_overflow = o;
        in_cout     = c;
        in_op       = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 00000000", out_result); end
        checks++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'd0) begin errors++; $display("FAIL reset_sticky: got %b/%0d expected 0/0", sticky_ovf, ovf_count); end
        $display("reset: done");
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 2'b00);  // ADD 5+3
        cyc();
        $display("stream: ADD 5+3 -> result %h valid %b", out_result, out_valid);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd8) begin errors++; $display("FAIL stream_add: got v=%b r=%h expected v=1 r=00000008", out_valid, out_result); end
        checks++; if ({out_zero, out_overflow, out_cout, out_negative} !== 4'b0000) begin errors++; $display("FAIL stream_add_flags: got %b expected 0000", {out_zero, out_overflow, out_cout, out_negative}); end
        drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 2'b01);  // SUB 3-3
        cyc();
        $display("stream: SUB 3-3 -> result %h zero %b", out_result, out_zero);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd0) begin errors++; $display("FAIL stream_sub: got v=%b r=%h expected v=1 r=00000000", out_valid, out_result); end
        checks++; if ({out_zero, out_overflow, out_cout, out_negative} !== 4'b1010) begin errors++; $display("FAIL stream_sub_flags: got %b expected 1010", {out_zero, out_overflow, out_cout, out_negative}); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_drain: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc();
        checks++; if (in_ready !== 1'b1 || out_result !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_first: got rdy=%b r=%h expected rdy=1 r=aaaa0001", in_ready, out_result); end
        drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc();
        checks++; if (in_ready !== 1'b0 || out_result !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_full: got rdy=%b r=%h expected rdy=0 r=aaaa0001", in_ready, out_result); end
        drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0, 2'b00);  // held by upstream
        cyc();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_hold: got rdy=%b v=%b r=%h expected rdy=0 v=1 r=aaaa0001", in_ready, out_valid, out_result); end
        out_ready = 1'b1;
        cyc();
        $display("back_pressure: pop A, head now %h", out_result);
        checks++; if (out_result !== 32'hBBBB_0002 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_a: got r=%h rdy=%b expected r=bbbb0002 rdy=1", out_result, in_ready); end
        cyc();
        $display("back_pressure: pop B, head now %h", out_result);
        checks++; if (out_result !== 32'hCCCC_0003 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_pop_b: got r=%h v=%b expected r=cccc0003 v=1", out_result, out_valid); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_pop_c: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_slt();
        out_ready = 1'b1;
        drive(1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 2'b11);
        cyc();
        $display("slt: result %h ovf %b cout %b neg %b", out_result, out_overflow, out_cout, out_negative);
        checks++; if (out_result !== 32'd1) begin errors++; $display("FAIL slt_result: got %h expected 00000001", out_result); end
        checks++; if ({out_overflow, out_cout, out_negative} !== 3'b000) begin errors++; $display("FAIL slt_mask: got %b expected 000", {out_overflow, out_cout, out_negative}); end
        checks++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'd0) begin errors++; $display("FAIL slt_sticky: got %b/%0d expected 0/0", sticky_ovf, ovf_count); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 2'b00);  // 0x7FFFFFFF + 1
        cyc();
        $display("overflow: result %h neg %b ovf %b count %0d", out_result, out_negative, out_overflow, ovf_count);
        checks++; if (out_negative !== 1'b1 || out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flags: got neg=%b ovf=%b expected 1/1", out_negative, out_overflow); end
        checks++; if (sticky_ovf !== 1'b1 || ovf_count !== 8'd1) begin errors++; $display("FAIL ovf_sticky: got %b/%0d expected 1/1", sticky_ovf, ovf_count); end
        drive(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 2'b01);
        sticky_clr = 1'b1;
        cyc();
        checks++; if (sticky_ovf !== 1'b1 || ovf_count !== 8'd1) begin errors++; $display("FAIL ovf_clr_set_wins: got %b/%0d expected 1/1", sticky_ovf, ovf_count); end
        drive(1'b1, 32'h8000_0002, 1'b0, 1'b1, 1'b0, 2'b00);
        sticky_clr = 1'b0;
        cyc();
        checks++; if (ovf_count !== 8'd2) begin errors++; $display("FAIL ovf_count_inc: got %0d expected 2", ovf_count); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
        sticky_clr = 1'b1;
        cyc();
        sticky_clr = 1'b0;
        checks++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'd0) begin errors++; $display("FAIL ovf_clr_alone: got %b/%0d expected 0/0", sticky_ovf, ovf_count); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 2'b00);
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (i == 254 || i == 255 || i == 300) begin
                $display("saturate: %0d accepts, count %0d", i, ovf_count);
                checks++;
                if (ovf_count !== CNT_W'((i > 255) ? 255 : i)) begin
                    errors++;
                    $display("FAIL sat_count_%0d: got %0d expected %0d", i, ovf_count, (i > 255) ? 255 : i);
                end
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
        sticky_clr = 1'b1;
        cyc();
        sticky_clr = 1'b0;
        checks++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'd0) begin errors++; $display("FAIL sat_clear: got %b/%0d expected 0/0", sticky_ovf, ovf_count); end
        cyc();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_0001, 1'b0, 1'b1, 1'b0, 2'b00);
        cyc();
        drive(1'b1, 32'hDEAD_0002, 1'b0, 1'b1, 1'b0, 2'b00);
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
        checks++; if (in_ready !== 1'b0 || ovf_count !== 8'd2) begin errors++; $display("FAIL mid_full: got rdy=%b cnt=%0d expected rdy=0 cnt=2", in_ready, ovf_count); end
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset_midstream: asynchronous reset asserted");
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_hs: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
        checks++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'd0 || out_result !== 32'h0) begin errors++; $display("FAIL mid_rst_state: got %b/%0d r=%h expected 0/0 r=00000000", sticky_ovf, ovf_count, out_result); end
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_dropped: got v=%b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_slt();
        test_overflow();
        test_saturate();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
